vga_timing_gen: RTL

- Parametrised raster timing generator for VGA-class displays.
- Successor to the fixed 640x480 timing block: generalises all horizontal/vertical intervals, sync polarity and pixel clock division.
- Adds a run enable, a synchronous frame restart, and line/frame start strobes.
- Feeds the pixel/sprite renderers (pixel, line, video) and the VGA pins (HS, VS).

---
 rtl/vga_timing_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = 2,
  parameter int   CW       = 12
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          enable,
  input  logic          sync_rst,
  output logic          pix_ce,
  output logic          HS,
  output logic          VS,
  output logic          video,
  output logic [CW-1:0] pixel,
  output logic [CW-1:0] line,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          tick;
  logic          h_wrap;
  logic          v_wrap;

  // Next raster position; level outputs are decoded from it so they land with the counters
  always_comb begin
    tick   = (div_cnt == DIV_LAST);
    h_wrap = (h_count == H_LAST);
    v_wrap = (v_count == V_LAST);
    h_next = h_wrap ? '0 : h_count + CW'(1);
    v_next = v_count;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : v_count + CW'(1);
    end
  end

  // Divider, raster counters and registered outputs; sync_rst wins over enable
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      div_cnt     <= '0;
      h_count     <= '0;
      v_count     <= '0;
      pix_ce      <= 1'b0;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      video       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (sync_rst) begin
      div_cnt     <= '0;
      h_count     <= '0;
      v_count     <= '0;
      pix_ce      <= 1'b0;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      video       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      pix_ce      <= tick;
      line_start  <= tick && h_wrap;
      frame_start <= tick && h_wrap && v_wrap;
      if (tick) begin
        div_cnt <= '0;
        h_count <= h_next;
        v_count <= v_next;
        video   <= (h_next < H_ACT) && (v_next < V_ACT);
        HS      <= ((h_next >= HS_START) && (h_next < HS_END)) ? HS_POL : ~HS_POL;
        VS      <= ((v_next >= VS_START) && (v_next < VS_END)) ? VS_POL : ~VS_POL;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end else begin
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  // Parameter legality guard for simulation only
  always_ff @(posedge clk) begin
    assert (H_SYNC > 0 && V_SYNC > 0 && CLK_DIV >= 1 && H_ACTIVE > 0 && V_ACTIVE > 0 &&
            (H_TOTAL < (1 << CW)) && (V_TOTAL < (1 << CW)))
      else $error("vga_timing_gen: illegal parameter set");
  end

  assign pixel = h_count;
  assign line  = v_count;

endmodule
